// File: rtl/mod_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mod_seq_pkg
// Description : Shared definitions for the shift-and-subtract divider and
//               its MSB priority encoders: controller state encoding, MSB
//               index width and the operand-width derivation helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mod_seq_pkg;

    // Controller states, 2-bit encoding.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALIGN = 2'd1,
        ST_SUB   = 2'd2
    } state_t;

    // Width of the MSB index produced by prio_enc.
    localparam int c_MSB_W = 8;

    // Operand width derived from its log2; shared by encoder and controller.
    function automatic int width_of(input int wl);
        return 1 << wl;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mod_seq_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : prio_enc
// Description : Priority encoder returning the index of the most significant
//               set bit of in_i (0 when in_i is zero). Two equivalent
//               implementations are selectable with FAST_ENCODER: a
//               log-depth binary search or a linear scan.
// Ports       : in_i  [WIDTH-1:0]   value to encode
//               msb_o [c_MSB_W-1:0] index of highest set bit, zero-extended
// Revision    : 1.0 - initial release
// ============================================================================
module prio_enc
    import mod_seq_pkg::*;
#(
    parameter  int WIDTH_LOG = 4,
    localparam int WIDTH     = width_of(WIDTH_LOG)
) (
    input  logic [WIDTH-1:0]   in_i,
    output logic [c_MSB_W-1:0] msb_o
);

`ifdef FAST_ENCODER
    localparam bit c_FAST = 1'b1;
`else
    localparam bit c_FAST = 1'b0;
`endif

    logic [WIDTH_LOG-1:0] w_idx;

    generate
        if (c_FAST) begin : g_fast
            // Binary search: each step asks whether anything lives in the
            // upper half of the remaining window and narrows accordingly.
            always_comb begin : p_search
                logic [WIDTH-1:0] v;
                v     = in_i;
                w_idx = '0;
                for (int k = WIDTH_LOG - 1; k >= 0; k--) begin
                    if ((v >> (1 << k)) != '0) begin
                        w_idx[k] = 1'b1;
                        v        = v >> (1 << k);
                    end
                end
            end
        end else begin : g_linear
            // Ascending scan: the last set bit seen is the most significant.
            always_comb begin : p_scan
                w_idx = '0;
                for (int i = 0; i < WIDTH; i++) begin
                    if (in_i[i]) begin
                        w_idx = i[WIDTH_LOG-1:0];
                    end
                end
            end
        end
    endgenerate

    assign msb_o = c_MSB_W'(w_idx);

endmodule
`default_nettype wire

// File: rtl/mod_seq.sv
`default_nettype none
// ============================================================================
// Module      : mod_seq
// Description : Sequential shift-and-subtract unsigned divider. The divisor
//               is pre-aligned to the dividend's MSB so only
//               (msb_a - msb_b + 1) subtract steps are needed.
// Ports       : clk   - rising-edge clock
//               rst   - synchronous active-high reset
//               go    - start request, sampled only while ready
//               a, b  - dividend / divisor, sampled with go
//               ready - idle, can accept go
//               done  - one-cycle pulse, rem/quo/err valid
//               rem   - a mod b
//               quo   - a / b
//               err   - divide-by-zero flag of the last operation
// Revision    : 1.0 - initial release
// ============================================================================
module mod_seq
    import mod_seq_pkg::*;
#(
    parameter  int WIDTH_LOG = 4,
    localparam int WIDTH     = width_of(WIDTH_LOG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] rem,
    output logic [WIDTH-1:0] quo,
    output logic             err
);

    // Working registers
    state_t               r_state_q, w_state_d;
    logic [WIDTH-1:0]     r_rem_q,   w_rem_d;
    logic [WIDTH-1:0]     r_div_q,   w_div_d;
    logic [WIDTH-1:0]     r_quo_q,   w_quo_d;
    logic [WIDTH_LOG-1:0] r_cnt_q,   w_cnt_d;

    // Result registers, only updated on completion
    logic [WIDTH-1:0]     r_rem_out_q, w_rem_out_d;
    logic [WIDTH-1:0]     r_quo_out_q, w_quo_out_d;
    logic                 r_err_q,     w_err_d;
    logic                 r_done_q,    w_done_d;

    logic [c_MSB_W-1:0]   w_msb_a;
    logic [c_MSB_W-1:0]   w_msb_b;
    logic [WIDTH_LOG-1:0] w_shift;
    logic                 w_ge;
    logic [WIDTH-1:0]     w_rem_sub;
    logic [WIDTH-1:0]     w_quo_shl;
    logic                 w_unused_msb;

    prio_enc #(
        .WIDTH_LOG (WIDTH_LOG)
    ) u_enc_a (
        .in_i  (r_rem_q),
        .msb_o (w_msb_a)
    );

    prio_enc #(
        .WIDTH_LOG (WIDTH_LOG)
    ) u_enc_b (
        .in_i  (r_div_q),
        .msb_o (w_msb_b)
    );

    // Only the low WIDTH_LOG bits of the encoder outputs carry information.
    assign w_unused_msb = ^{w_msb_a[c_MSB_W-1:WIDTH_LOG], w_msb_b[c_MSB_W-1:WIDTH_LOG]};

    // Only consumed in ALIGN when rem >= div, so msb_a >= msb_b holds.
    assign w_shift   = w_msb_a[WIDTH_LOG-1:0] - w_msb_b[WIDTH_LOG-1:0];

    // Subtraction is guarded by w_ge, so no borrow out is possible.
    assign w_ge      = (r_rem_q >= r_div_q);
    assign w_rem_sub = w_ge ? (r_rem_q - r_div_q) : r_rem_q;
    assign w_quo_shl = {r_quo_q[WIDTH-2:0], w_ge};

    always_comb begin
        w_state_d   = r_state_q;
        w_rem_d     = r_rem_q;
        w_div_d     = r_div_q;
        w_quo_d     = r_quo_q;
        w_cnt_d     = r_cnt_q;
        w_rem_out_d = r_rem_out_q;
        w_quo_out_d = r_quo_out_q;
        w_err_d     = r_err_q;
        w_done_d    = 1'b0;

        unique case (r_state_q)
            ST_IDLE: begin
                if (go) begin
                    w_rem_d   = a;
                    w_div_d   = b;
                    w_quo_d   = '0;
                    w_cnt_d   = '0;
                    w_state_d = ST_ALIGN;
                end
            end

            ST_ALIGN: begin
                if (r_div_q == '0) begin
                    w_err_d     = 1'b1;
                    w_rem_out_d = r_rem_q;
                    w_quo_out_d = '0;
                    w_done_d    = 1'b1;
                    w_state_d   = ST_IDLE;
                end else if (r_rem_q < r_div_q) begin
                    w_err_d     = 1'b0;
                    w_rem_out_d = r_rem_q;
                    w_quo_out_d = '0;
                    w_done_d    = 1'b1;
                    w_state_d   = ST_IDLE;
                end else begin
                    // msb_b + shift = msb_a, so the shifted divisor fits.
                    w_div_d   = r_div_q << w_shift;
                    w_cnt_d   = w_shift;
                    w_state_d = ST_SUB;
                end
            end

            ST_SUB: begin
                w_rem_d = w_rem_sub;
                w_quo_d = w_quo_shl;
                if (r_cnt_q == '0) begin
                    w_err_d     = 1'b0;
                    w_rem_out_d = w_rem_sub;
                    w_quo_out_d = w_quo_shl;
                    w_done_d    = 1'b1;
                    w_state_d   = ST_IDLE;
                end else begin
                    w_div_d = r_div_q >> 1;
                    w_cnt_d = r_cnt_q - 1'b1;
                end
            end

            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q   <= ST_IDLE;
            r_rem_q     <= '0;
            r_div_q     <= '0;
            r_quo_q     <= '0;
            r_cnt_q     <= '0;
            r_rem_out_q <= '0;
            r_quo_out_q <= '0;
            r_err_q     <= 1'b0;
            r_done_q    <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_rem_q     <= w_rem_d;
            r_div_q     <= w_div_d;
            r_quo_q     <= w_quo_d;
            r_cnt_q     <= w_cnt_d;
            r_rem_out_q <= w_rem_out_d;
            r_quo_out_q <= w_quo_out_d;
            r_err_q     <= w_err_d;
            r_done_q    <= w_done_d;
        end
    end

    // Ready follows the state register, so it rises together with done.
    assign ready = (r_state_q == ST_IDLE);
    assign done  = r_done_q;
    assign rem   = r_rem_out_q;
    assign quo   = r_quo_out_q;
    assign err   = r_err_q;

endmodule
`default_nettype wire
